mpsk_phase_gen: RTL and testbench

Parametrised M-PSK phase generator. It is the successor to the fixed QPSK path of DRBG, 3-bit SIPO, phase mux, sample counter and adder.
- Collects serial bits through a valid/ready handshake into BITS_PER_SYM-bit symbols.
- Gray-decodes each symbol to a phase offset.
- Adds the offset to a free-running carrier phase accumulator.
- Emits a PHASE_W-bit sine-LUT address per sample, with symbol timing, pause and underrun handling.
- Sits between the bit source (DRBG) and the sine LUT / DAC stage.

---
 rtl/mpsk_pkg.sv | 30 +++
 rtl/mpsk_bit_collector.sv | 76 +++++++
 rtl/mpsk_phase_gen.sv | 138 +++++++++++++
 tb/tb_mpsk_phase_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsk_pkg.sv
// Shared constants and helpers for the M-PSK phase generator.
package mpsk_pkg;

  localparam int unsigned MAX_BITS = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Width of a counter that must hold 0..sps-1.
  function automatic int unsigned cnt_w(input int unsigned sps);
    return (sps > 2) ? $clog2(sps) : 1;
  endfunction

  // Gray-to-binary over the low nbits; bits above nbits are forced to zero.
  function automatic logic [MAX_BITS-1:0] gray2bin(input logic [MAX_BITS-1:0] g,
                                                   input int unsigned nbits);
    logic [MAX_BITS-1:0] b;
    logic                run;
    b   = '0;
    run = 1'b0;
    for (int i = MAX_BITS - 1; i >= 0; i--) begin
      if (i < int'(nbits)) begin
        run  = run ^ g[i];
        b[i] = run;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/mpsk_bit_collector.sv
// Serial-in symbol collector: MSB-first SIPO with a one-deep pending buffer.
module mpsk_bit_collector
  import mpsk_pkg::*;
#(
  parameter int unsigned BITS_PER_SYM = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic                    consume,
  output logic                    bit_ready,
  output logic                    pend_full,
  output logic [BITS_PER_SYM-1:0] pend_sym
);

  localparam int unsigned CNT_W = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;

  logic [BITS_PER_SYM-1:0] shift_q, shift_d;
  logic [BITS_PER_SYM-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    pend_full_q, pend_full_d;
  logic                    ready_q, ready_d;
  logic                    take;
  logic                    last_bit;
  logic [BITS_PER_SYM-1:0] shift_nxt;

  // Shift accepted bits in; hand a full symbol to the pending slot.
  always_comb begin
    shift_d     = shift_q;
    pend_d      = pend_q;
    bit_cnt_d   = bit_cnt_q;
    pend_full_d = pend_full_q;
    take        = bit_valid && ready_q;
    shift_nxt   = BITS_PER_SYM'({shift_q, bit_in});
    last_bit    = (bit_cnt_q == CNT_W'(BITS_PER_SYM - 1));
    if (consume) begin
      pend_full_d = 1'b0;
    end
    if (take) begin
      if (last_bit) begin
        pend_d      = shift_nxt;
        pend_full_d = 1'b1;
        bit_cnt_d   = '0;
        shift_d     = '0;
      end else begin
        shift_d   = shift_nxt;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
    // Registered so ready stays low during reset and tracks !pend_full after.
    ready_d = !pend_full_d;
  end

  // Collector state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      pend_q      <= '0;
      bit_cnt_q   <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
    end
  end

  assign bit_ready = ready_q;
  assign pend_full = pend_full_q;
  assign pend_sym  = pend_q;

endmodule

// File: rtl/mpsk_phase_gen.sv
// M-PSK phase generator: symbol timing, Gray mapping and carrier phase accumulation.
module mpsk_phase_gen
  import mpsk_pkg::*;
#(
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned PHASE_W      = 8,
  parameter int unsigned SPS          = 256,
  parameter int unsigned FREQ_STEP    = 1,
  parameter int unsigned GRAY         = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [PHASE_W-1:0] phase_out,
  output logic               out_valid,
  output logic               sym_start,
  output logic               underrun
);

  localparam int unsigned CNT_W = cnt_w(SPS);
  localparam int unsigned SHIFT = PHASE_W - BITS_PER_SYM;

  logic [0:0]              state_q, state_d;
  logic [PHASE_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] act_q, act_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sym_start_q, sym_start_d;
  logic                    underrun_q, underrun_d;

  logic                    consume;
  logic                    pend_full;
  logic [BITS_PER_SYM-1:0] pend_sym;
  logic [BITS_PER_SYM-1:0] dec;
  logic [PHASE_W-1:0]      offset;
  logic                    last_sample;

  mpsk_bit_collector #(
    .BITS_PER_SYM (BITS_PER_SYM)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .consume   (consume),
    .bit_ready (bit_ready),
    .pend_full (pend_full),
    .pend_sym  (pend_sym)
  );

  // Next-state, accumulator and mapped output for the current sample.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    phase_d     = phase_q;
    out_valid_d = 1'b0;
    sym_start_d = 1'b0;
    underrun_d  = 1'b0;
    consume     = 1'b0;

    if (GRAY != 0) begin
      dec = BITS_PER_SYM'(gray2bin(MAX_BITS'(act_q), BITS_PER_SYM));
    end else begin
      dec = act_q;
    end
    offset      = PHASE_W'(dec) << SHIFT;
    last_sample = (cnt_q == CNT_W'(SPS - 1));

    case (state_q)
      ST_IDLE: begin
        if (enable && pend_full) begin
          consume = 1'b1;
          act_d   = pend_sym;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (enable) begin
          phase_d     = acc_q + offset;
          out_valid_d = 1'b1;
          sym_start_d = (cnt_q == '0);
          acc_d       = acc_q + PHASE_W'(FREQ_STEP);
          if (last_sample) begin
            cnt_d = '0;
            if (pend_full) begin
              consume = 1'b1;
              act_d   = pend_sym;
            end else begin
              underrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      act_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      sym_start_q <= sym_start_d;
      underrun_q  <= underrun_d;
    end
  end

  assign phase_out = phase_q;
  assign out_valid = out_valid_q;
  assign sym_start = sym_start_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_mpsk_phase_gen.sv
// Scoreboard bench for mpsk_phase_gen: QPSK/Gray instance plus an 8-PSK binary instance.
module tb_mpsk_phase_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0;
  logic       bit_in2 = 1'b0, bit_valid2 = 1'b0;

  logic       bit_ready, out_valid, sym_start, underrun;
  logic [7:0] phase_out;
  logic       bit_ready2, out_valid2, sym_start2, underrun2;
  logic [7:0] phase_out2;

  typedef struct packed {
    logic [7:0] ph;
    logic       ss;
    logic       ur;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mpsk_phase_gen #(
    .BITS_PER_SYM (2), .PHASE_W (8), .SPS (4), .FREQ_STEP (64), .GRAY (1)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable), .bit_in (bit_in), .bit_valid (bit_valid),
    .bit_ready (bit_ready), .phase_out (phase_out), .out_valid (out_valid),
    .sym_start (sym_start), .underrun (underrun)
  );

  mpsk_phase_gen #(
    .BITS_PER_SYM (3), .PHASE_W (8), .SPS (4), .FREQ_STEP (0), .GRAY (0)
  ) dut2 (
    .clk (clk), .rst (rst), .enable (enable), .bit_in (bit_in2), .bit_valid (bit_valid2),
    .bit_ready (bit_ready2), .phase_out (phase_out2), .out_valid (out_valid2),
    .sym_start (sym_start2), .underrun (underrun2)
  );

  function automatic exp_t mk(input int ph, input bit ss, input bit ur);
    exp_t e;
    e.ph = 8'(ph);
    e.ss = ss;
    e.ur = ur;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Push 4 samples of one symbol; sym_start on the first, underrun optional on the last.
  task automatic push4(input int which, input int p0, input int p1, input int p2,
                       input int p3, input bit ur_last);
    exp_t e[4];
    e[0] = mk(p0, 1'b1, 1'b0);
    e[1] = mk(p1, 1'b0, 1'b0);
    e[2] = mk(p2, 1'b0, 1'b0);
    e[3] = mk(p3, 1'b0, ur_last);
    for (int i = 0; i < 4; i++) begin
      if (which == 1) q1.push_back(e[i]);
      else            q2.push_back(e[i]);
    end
  endtask

  // Monitor for the QPSK instance.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL dut1_unexpected: got ph=%0d ss=%0b ur=%0b expected no output",
                 phase_out, sym_start, underrun);
      end else begin
        e = q1.pop_front();
        if ({phase_out, sym_start, underrun} !== e) begin
          bad++;
          $display("FAIL dut1_sample: got ph=%0d ss=%0b ur=%0b expected ph=%0d ss=%0b ur=%0b",
                   phase_out, sym_start, underrun, e.ph, e.ss, e.ur);
        end
      end
    end
  end

  // Monitor for the 8-PSK instance.
  always @(negedge clk) begin
    if (!rst && out_valid2) begin
      exp_t e;
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL dut2_unexpected: got ph=%0d expected no output", phase_out2);
      end else begin
        e = q2.pop_front();
        if ({phase_out2, sym_start2, underrun2} !== e) begin
          bad++;
          $display("FAIL dut2_sample: got ph=%0d ss=%0b ur=%0b expected ph=%0d ss=%0b ur=%0b",
                   phase_out2, sym_start2, underrun2, e.ph, e.ss, e.ur);
        end
      end
    end
  end

  // Present one bit and hold it until it transfers; leaves bit_valid asserted.
  task automatic send_bit(input int which, input logic b);
    int n;
    logic rdy;
    n = 0;
    if (which == 1) begin bit_valid = 1'b1; bit_in = b; end
    else            begin bit_valid2 = 1'b1; bit_in2 = b; end
    do begin
      @(negedge clk);
      n++;
      rdy = (which == 1) ? bit_ready : bit_ready2;
    end while (!rdy && n < 100);
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got bit_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    bit_valid  = 1'b0;
    bit_valid2 = 1'b0;
  endtask

  // Wait until the chosen queue has shrunk to n entries.
  task automatic wait_size(input int which, input int n);
    int c;
    c = 0;
    while (((which == 1) ? q1.size() : q2.size()) > n && c < 200) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (((which == 1) ? q1.size() : q2.size()) > n) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected %0d",
               (which == 1) ? q1.size() : q2.size(), n);
    end
  endtask

  // Drain both scoreboards, then reset both instances to stop repeating output.
  task automatic end_test();
    wait_size(1, 0);
    wait_size(2, 0);
    q1.delete();
    q2.delete();
    rst = 1'b1;
    drop_valid();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state.
    #12;
    chk("rst_phase", 32'(phase_out), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sym_start", 32'(sym_start), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_bit_ready", 32'(bit_ready), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b1;

    // Start-up: bits 1,1 -> gray 11 = 2, offset 128, repeated once with underruns.
    push4(1, 128, 192, 0, 64, 1'b1);
    push4(1, 128, 192, 0, 64, 1'b1);
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    drop_valid();
    end_test();

    // Back-to-back: 00 then 01 with valid held; ready drops after each pair.
    push4(1, 0, 64, 128, 192, 1'b0);
    push4(1, 64, 128, 192, 0, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b0);
    @(negedge clk);
    chk("b2b_ready_low_1", 32'(bit_ready), 0);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    @(negedge clk);
    chk("b2b_ready_low_2", 32'(bit_ready), 0);
    drop_valid();
    end_test();

    // Underrun: single symbol 10 -> offset 192, repeats with underrun each boundary.
    push4(1, 192, 0, 64, 128, 1'b1);
    push4(1, 192, 0, 64, 128, 1'b1);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    drop_valid();
    end_test();

    // Pause for 3 cycles after the second sample; sequence resumes without gap.
    push4(1, 0, 64, 128, 192, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b0);
    drop_valid();
    wait_size(1, 2);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pause_valid", 32'(out_valid), 0);
    end
    #1;
    enable = 1'b1;
    end_test();

    // Reset mid-symbol, asserted between edges.
    push4(1, 128, 192, 0, 64, 1'b1);
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    drop_valid();
    wait_size(1, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_phase", 32'(phase_out), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    q1.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    send_bit(1, 1'b0);
    drop_valid();
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_output", 32'(out_valid), 0);
    end
    #1;
    push4(1, 64, 128, 192, 0, 1'b1);
    send_bit(1, 1'b1);
    drop_valid();
    end_test();

    // 8-PSK natural binary, zero step: bits 1,0,1 -> constant 160.
    push4(2, 160, 160, 160, 160, 1'b1);
    push4(2, 160, 160, 160, 160, 1'b1);
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    send_bit(2, 1'b1);
    drop_valid();
    end_test();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
